// File: rtl/hazard_if.sv
// Hazard-control bundle between the 5-stage datapath and hazard_ctrl.
// The datapath is the master: it reports pipeline status and consumes stall/clear.
interface hazard_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [4:0] ex_rd;
  logic       ex_load;
  logic       ex_redirect;
  logic       ex_mc_start;
  logic       ex_mc_done;
  logic       mem_req;
  logic       mem_ready;
  logic       pc_stall;
  logic       if_id_stall;
  logic       if_id_clear;
  logic       id_ex_stall;
  logic       id_ex_clear;
  logic       ex_mem_stall;
  logic       ex_mem_clear;
  logic       mem_wb_clear;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_load, ex_redirect,
           ex_mc_start, ex_mc_done, mem_req, mem_ready,
    input  pc_stall, if_id_stall, if_id_clear, id_ex_stall, id_ex_clear,
           ex_mem_stall, ex_mem_clear, mem_wb_clear
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_load, ex_redirect,
           ex_mc_start, ex_mc_done, mem_req, mem_ready,
    output pc_stall, if_id_stall, if_id_clear, id_ex_stall, id_ex_clear,
           ex_mem_stall, ex_mem_clear, mem_wb_clear
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use, redirect, data-memory wait and
// multi-cycle EX wait handling, with a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  hazard_if.slave          hz,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cycles
);
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, MC_WAIT = 2'd2} state_t;

  // {pc_stall, if_id_stall, if_id_clear, id_ex_stall, id_ex_clear, ex_mem_stall, ex_mem_clear, mem_wb_clear}
  localparam logic [7:0] C_FREEZE = 8'b1101_0101;
  localparam logic [7:0] C_MC     = 8'b1101_0010;
  localparam logic [7:0] C_RED    = 8'b0010_1000;
  localparam logic [7:0] C_LU     = 8'b1100_1000;

  state_t           state, state_nx;
  logic             lu, mw, run_eval;
  logic [7:0]       ctl;
  logic [CNT_W-1:0] cnt;

  assign lu = hz.ex_load && (hz.ex_rd != 5'd0) &&
              ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
               (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));
  assign mw = hz.mem_req && !hz.mem_ready;

  always_comb begin
    ctl      = '0;
    state_nx = state;
    run_eval = 1'b0;
    case (state)
      RUN:      run_eval = 1'b1;
      MEM_WAIT: if (!hz.mem_ready) ctl = C_FREEZE;
                else run_eval = 1'b1;   // EX was frozen, so re-judge it on release
      MC_WAIT: begin
        if (mw)                  ctl = C_FREEZE;
        else if (!hz.ex_mc_done) ctl = C_MC;
        else                     state_nx = RUN;
      end
      default:  state_nx = RUN;
    endcase
    if (run_eval) begin
      state_nx = RUN;
      if (mw) begin
        ctl      = C_FREEZE;
        state_nx = MEM_WAIT;
      end else if (hz.ex_mc_start && !hz.ex_mc_done) begin
        ctl      = C_MC;
        state_nx = MC_WAIT;
      end else if (hz.ex_redirect) begin
        ctl = C_RED;
      end else if (lu) begin
        ctl = C_LU;
      end
    end
    if (rst) ctl = '0;
  end

  assign {hz.pc_stall, hz.if_id_stall, hz.if_id_clear, hz.id_ex_stall,
          hz.id_ex_clear, hz.ex_mem_stall, hz.ex_mem_clear, hz.mem_wb_clear} = ctl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (ctl[7] && (cnt != {CNT_W{1'b1}}))
        cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign ctrl_state   = state;
  assign stall_cycles = cnt;
endmodule
